// File: rtl/seq_det_pkg.sv
// Shared definitions for the serial pattern detector: FSM state encoding and counter limits.
package seq_det_pkg;

  typedef enum logic [1:0] {
    DISABLED = 2'd0,
    FILL     = 2'd1,
    HUNT     = 2'd2
  } state_t;

  localparam int MATCH_CNT_W_DEF = 8;
  localparam logic [MATCH_CNT_W_DEF-1:0] CNT_MAX = '1;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter; synchronous clear has priority over increment.
module sat_counter #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         inc,
  input  logic         clr,
  output logic [W-1:0] out
);

  logic [W-1:0] r_cnt;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_cnt <= '0;
    end else if (clr) begin
      r_cnt <= '0;
    end else if (inc && (r_cnt != {W{1'b1}})) begin
      r_cnt <= r_cnt + W'(1);
    end
  end

  assign out = r_cnt;

endmodule

// File: rtl/seq_pattern_detector.sv
// Serial pattern detector: flags each PAT_W-bit occurrence of PATTERN in a valid-qualified
// bit stream, with overlapping or flushing match semantics and a saturating match counter.
module seq_pattern_detector
  import seq_det_pkg::*;
#(
  parameter int                 PAT_W       = 4,
  parameter logic [PAT_W-1:0]   PATTERN     = 4'b1011,
  parameter bit                 OVERLAP     = 1'b1,
  parameter int                 MATCH_CNT_W = MATCH_CNT_W_DEF
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   en,
  input  logic                   in_valid,
  input  logic                   in,
  input  logic                   clr_cnt,
  output logic                   armed,
  output logic                   match,
  output logic [MATCH_CNT_W-1:0] match_cnt
);

  localparam int FILL_W = $clog2(PAT_W + 1);
  localparam logic [FILL_W-1:0] FILL_LAST = FILL_W'(PAT_W - 1);

  state_t             r_state;
  logic [PAT_W-1:0]   r_hist;
  logic [FILL_W-1:0]  r_fill;
  logic               r_match;
  logic               r_armed;

  logic               w_acc;
  logic [PAT_W-1:0]   w_hist_nxt;
  logic               w_complete;
  logic               w_hit;

  assign w_acc      = en & in_valid;
  assign w_hist_nxt = {r_hist[PAT_W-2:0], in};
  // A bit in DISABLED (with en high) is accepted as the first fill bit.
  assign w_complete = (r_state == HUNT) || (r_fill == FILL_LAST);
  assign w_hit      = w_acc && w_complete && (w_hist_nxt == PATTERN);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= DISABLED;
      r_hist  <= '0;
      r_fill  <= '0;
      r_match <= 1'b0;
      r_armed <= 1'b0;
    end else if (!en) begin
      r_state <= DISABLED;
      r_hist  <= '0;
      r_fill  <= '0;
      r_match <= 1'b0;
      r_armed <= 1'b0;
    end else begin
      r_match <= w_hit;
      if (w_acc) begin
        if (w_hit && !OVERLAP) begin
          r_hist  <= '0;
          r_fill  <= '0;
          r_state <= FILL;
          r_armed <= 1'b0;
        end else if (r_state == HUNT || r_fill == FILL_LAST) begin
          r_hist  <= w_hist_nxt;
          r_fill  <= FILL_LAST;
          r_state <= HUNT;
          r_armed <= 1'b1;
        end else begin
          r_hist  <= w_hist_nxt;
          r_fill  <= r_fill + FILL_W'(1);
          r_state <= FILL;
          r_armed <= 1'b0;
        end
      end else if (r_state == DISABLED) begin
        r_state <= FILL;
      end
    end
  end

  // Counter steps on the same edge that raises match, so clr_cnt alongside wins cleanly.
  sat_counter #(
    .W (MATCH_CNT_W)
  ) u_cnt (
    .clk   (clk),
    .reset (reset),
    .inc   (w_hit),
    .clr   (clr_cnt),
    .out   (match_cnt)
  );

  assign match = r_match;
  assign armed = r_armed;

endmodule
